// File: rtl/encoder_64b66b_if.sv
// Valid/ready stream bundle shared by the encoder's payload input and line output.
interface encoder_64b66b_if;
    logic [1:0]  ttype;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output ttype, output tdata, output tvalid, input tready);
    modport slave  (input ttype, input tdata, input tvalid, output tready);
endinterface

// File: rtl/encoder_64b66b.sv
// 64b/66b transmit PCS: x^58+x^39+1 scrambler then 66->64 gearbox; latency 2 cycles.
// Backpressure: m_axis.tready low freezes every stage; the input stalls one cycle per 33 to drain the residue.
module encoder_64b66b (
    input  logic               clk,
    input  logic               reset_n,
    encoder_64b66b_if.slave    s_axis,
    encoder_64b66b_if.master   m_axis
);

    logic        s1_valid;
    logic [1:0]  s1_type;
    logic [63:0] s1_data;

    logic [57:0] scr_state;
    logic [57:0] scr_next;
    logic [63:0] scr_data;

    logic [6:0]  r;
    logic [63:0] res;
    logic [63:0] m_data;
    logic        m_valid;

    logic        out_can_load;
    logic        s1_take;
    logic        drain;
    logic        s_accept;
    logic [65:0] block;
    logic [127:0] cat;

    // Serial scrambler unrolled over the word; bit 0 is the first bit on the line.
    always_comb begin
        scr_next = scr_state;
        scr_data = '0;
        for (int i = 0; i < 64; i++) begin
            scr_data[i] = s_axis.tdata[i] ^ scr_next[38] ^ scr_next[57];
            scr_next    = {scr_next[56:0], scr_data[i]};
        end
    end

    assign out_can_load  = !m_valid || m_axis.tready;
    assign drain         = (r == 7'd64) && out_can_load;
    assign s1_take       = s1_valid && out_can_load && (r != 7'd64);
    assign s_axis.tready = !s1_valid || s1_take;
    assign s_accept      = s_axis.tvalid && s_axis.tready;

    // Residue bits above r are always zero, so the OR needs no mask.
    assign block = {s1_data, s1_type};
    assign cat   = ({62'd0, block} << r) | {64'd0, res};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_type   <= 2'b00;
            s1_data   <= '0;
            scr_state <= '1;
        end else if (s_accept) begin
            s1_valid  <= 1'b1;
            s1_type   <= s_axis.ttype;
            s1_data   <= scr_data;
            scr_state <= scr_next;
        end else if (s1_take) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            res     <= '0;
            r       <= '0;
        end else if (drain) begin
            m_valid <= 1'b1;
            m_data  <= res;
            res     <= '0;
            r       <= '0;
        end else if (s1_take) begin
            m_valid <= 1'b1;
            m_data  <= cat[63:0];
            res     <= cat[127:64];
            r       <= r + 7'd2;
        end else if (out_can_load) begin
            m_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    // The line side carries no sync-header sideband; headers travel inside tdata.
    assign m_axis.ttype  = 2'b00;

endmodule

// File: tb/tb_encoder_64b66b.sv
module tb_encoder_64b66b;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    encoder_64b66b_if s_if ();
    encoder_64b66b_if m_if ();

    encoder_64b66b dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_axis  (s_if),
        .m_axis  (m_if)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int bp_mode = 0;
    bit cad_mode = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit          bit_q[$];
    bit          hist[$];
    int          drop_cycles[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: line is a serial bit stream; scrambler taps read from the history of scrambled bits.
    task automatic model_reset();
        exp_q.delete();
        bit_q.delete();
        hist.delete();
        for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    endtask

    task automatic model_push(input logic [1:0] t, input logic [63:0] d);
        bit b;
        logic [63:0] w;
        bit_q.push_back(t[0]);
        bit_q.push_back(t[1]);
        for (int i = 0; i < 64; i++) begin
            // hist[0] is 58 bits back, hist[19] is 39 bits back
            b = d[i] ^ hist[19] ^ hist[0];
            hist.push_back(b);
            void'(hist.pop_front());
            bit_q.push_back(b);
        end
        while (bit_q.size() >= 64) begin
            for (int j = 0; j < 64; j++) w[j] = bit_q.pop_front();
            exp_q.push_back(w);
        end
    endtask

    // Monitor / scoreboard
    logic        prev_stall = 1'b0;
    logic [63:0] prev_dat;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 64'(m_if.tvalid), 64'd1);
                check("hold_dat", m_if.tdata, prev_dat);
            end
            if (m_if.tvalid && m_if.tready) begin
                got_q.push_back(m_if.tdata);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %h want none (cycle %0d)", m_if.tdata, cycle);
                end else begin
                    check("word", m_if.tdata, exp_q.pop_front());
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_dat   = m_if.tdata;
            if (cad_mode && s_if.tvalid && !s_if.tready) drop_cycles.push_back(cycle);
        end
    end

    // Output-ready generator: mode 0 always ready, mode 1 random with 5-cycle low bursts.
    initial begin
        int burst;
        burst = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                m_if.tready = 1'b1;
                burst = 0;
            end else if (burst > 0) begin
                m_if.tready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 19) == 0) begin
                m_if.tready = 1'b0;
                burst = 4;
            end else begin
                m_if.tready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic send_block(input logic [1:0] t, input logic [63:0] d);
        int n;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.ttype  = t;
        s_if.tdata  = d;
        forever begin
            @(negedge clk);
            if (s_if.tready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no tready want tready within 200 cycles");
            s_if.tvalid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_push(t, d);
        end
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [1:0] rnd_type();
        logic [1:0] t;
        if ($urandom_range(0, 15) == 0) t = 2'($urandom_range(0, 3));
        else t = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.ttype  = 2'b00;
        s_if.tdata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset_s_tready", 64'(s_if.tready), 64'd1);
        check("reset_m_tdata", m_if.tdata, 64'd0);
        @(posedge clk);
        #1;

        // Known vector, header alignment, illegal header injection
        got_q.delete();
        send_block(2'b01, 64'd0);
        send_block(2'b10, rnd64());
        send_block(2'b00, rnd64());
        send_block(2'b01, rnd64());
        idle(2);
        wait_drain();
        check("first_words", 64'(got_q.size()), 64'd4);
        check("known_vector", got_q[0], 64'h0FFF_FE00_0000_0001);
        check("hdr_blk0", 64'(got_q[0][1:0]), 64'd1);
        check("hdr_blk1", 64'(got_q[1][3:2]), 64'd2);
        check("hdr_illegal", 64'(got_q[2][5:4]), 64'd0);

        // Reset in the middle of a backpressured stream
        bp_mode = 1;
        for (int i = 0; i < 20; i++) send_block(rnd_type(), rnd64());
        s_if.tvalid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        bp_mode = 0;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_if.tready), 64'd1);
        check("midrst_m_tdata", m_if.tdata, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_q.delete();
        send_block(2'b10, rnd64());
        send_block(2'b01, rnd64());
        idle(2);
        wait_drain();
        check("fresh_hdr", 64'(got_q[0][1:0]), 64'd2);

        // Cadence: back-to-back blocks with the output always ready
        do_reset();
        got_q.delete();
        drop_cycles.delete();
        cad_mode = 1'b1;
        for (int i = 0; i < 66; i++) send_block(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, rnd64());
        cad_mode = 1'b0;
        idle(2);
        wait_drain();
        check("cad_words", 64'(got_q.size()), 64'd68);
        check("cad_drops", 64'(drop_cycles.size()), 64'd2);
        if (drop_cycles.size() >= 2)
            check("cad_spacing", 64'(drop_cycles[1] - drop_cycles[0]), 64'd33);

        // Long random stream with random backpressure and input gaps
        do_reset();
        bp_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send_block(rnd_type(), rnd64());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
        wait_drain();
        bp_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
